// File: rtl/gpu_rect_sequencer_pkg.sv
// Shared constants for the rect sequencer and the GPU receiver FSM.
// Holds phase codes, counter widths and the rect record field-offset helper.
package gpu_rect_sequencer_pkg;

    localparam int COORD_WIDTH      = 10;
    localparam int RECT_COUNT_WIDTH = 4;
    localparam int RECTS_PER_BATCH  = 16;
    localparam int RECT_WORDS       = 5;

    typedef enum logic [2:0] {
        PH_IDLE   = 3'd0,
        PH_X      = 3'd1,
        PH_WIDTH  = 3'd2,
        PH_Y      = 3'd3,
        PH_HEIGHT = 3'd4,
        PH_COLOR  = 3'd5
    } phase_t;

    // Word offset of a phase's field inside a 5-word rect record.
    function automatic logic [2:0] field_offset(input phase_t ph);
        logic [2:0] off;
        off = 3'd0;
        case (ph)
            PH_X:      off = 3'd0;
            PH_Y:      off = 3'd1;
            PH_WIDTH:  off = 3'd2;
            PH_HEIGHT: off = 3'd3;
            PH_COLOR:  off = 3'd4;
            default:   off = 3'd0;
        endcase
        return off;
    endfunction

    // Phase that follows a finished sweep.
    function automatic phase_t next_phase(input phase_t ph);
        phase_t nx;
        nx = PH_IDLE;
        case (ph)
            PH_X:      nx = PH_WIDTH;
            PH_WIDTH:  nx = PH_Y;
            PH_Y:      nx = PH_HEIGHT;
            PH_HEIGHT: nx = PH_COLOR;
            default:   nx = PH_IDLE;
        endcase
        return nx;
    endfunction

endpackage

// File: rtl/gpu_rect_fetch_pipe.sv
// Data path of the rect sequencer: aligns rect memory data with the receiver.
// Ports: clk, reset (sync, active-high); i_phase/i_load/i_rect = control
// driven in the same cycle as the memory address; i_rdata = memory data one
// cycle later; o_dout = processed word, three cycles after the control.
module gpu_rect_fetch_pipe
    import gpu_rect_sequencer_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  phase_t                      i_phase,
    input  logic                        i_load,
    input  logic [RECT_COUNT_WIDTH-1:0] i_rect,
    input  logic [15:0]                 i_rdata,
    output logic [15:0]                 o_dout
);

    // Control delayed one cycle so it lines up with i_rdata.
    phase_t                      r_d1_phase;
    logic                        r_d1_load;
    logic [RECT_COUNT_WIDTH-1:0] r_d1_rect;

    // Stage 1: captured data plus its control.
    phase_t                      r_s1_phase;
    logic                        r_s1_load;
    logic [RECT_COUNT_WIDTH-1:0] r_s1_rect;
    logic [15:0]                 r_s1_data;

    logic [COORD_WIDTH-1:0]      r_edge [RECTS_PER_BATCH];
    logic [15:0]                 r_dout;

    logic [COORD_WIDTH:0]        w_sum;
    logic [COORD_WIDTH-1:0]      w_sat;
    logic [15:0]                 w_out;
    logic                        w_edge_we;

    // Leading edges (x, y) are remembered so the far edge can be formed
    // when the matching size field arrives.
    assign w_edge_we = r_d1_load &&
                       (r_d1_phase == PH_X || r_d1_phase == PH_Y);

    always_comb begin
        w_sum = {1'b0, r_edge[r_s1_rect]} +
                {1'b0, r_s1_data[COORD_WIDTH-1:0]};
        w_sat = w_sum[COORD_WIDTH] ? {COORD_WIDTH{1'b1}}
                                   : w_sum[COORD_WIDTH-1:0];
        w_out = '0;
        case (r_s1_phase)
            PH_X, PH_Y: begin
                if (r_s1_load)
                    w_out = {6'b0, r_s1_data[COORD_WIDTH-1:0]};
            end
            PH_WIDTH, PH_HEIGHT: begin
                if (r_s1_load)
                    w_out = {6'b0, w_sat};
            end
            PH_COLOR: w_out = r_s1_data;
            default:  w_out = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_d1_phase <= PH_IDLE;
            r_d1_load  <= 1'b0;
            r_d1_rect  <= '0;
            r_s1_phase <= PH_IDLE;
            r_s1_load  <= 1'b0;
            r_s1_rect  <= '0;
            r_s1_data  <= '0;
            r_dout     <= '0;
            for (int k = 0; k < RECTS_PER_BATCH; k++)
                r_edge[k] <= '0;
        end else begin
            r_d1_phase <= i_phase;
            r_d1_load  <= i_load;
            r_d1_rect  <= i_rect;
            r_s1_phase <= r_d1_phase;
            r_s1_load  <= r_d1_load;
            r_s1_rect  <= r_d1_rect;
            r_s1_data  <= i_rdata;
            r_dout     <= w_out;
            if (w_edge_we)
                r_edge[r_d1_rect] <= i_rdata[COORD_WIDTH-1:0];
        end
    end

    assign o_dout = r_dout;

endmodule

// File: rtl/gpu_rect_sequencer.sv
// Frame sequencer: walks rect batches through X/WIDTH/Y/HEIGHT/COLOR phases.
// Ports: clk, reset (sync, active-high), start pulse; mem_addr/mem_rdata rect
// memory (1-cycle latency); state, coord_generator, rect_counter,
// batch_counter, batch_completed, dout to the receiver; busy, done status.
module gpu_rect_sequencer
    import gpu_rect_sequencer_pkg::*;
#(
    parameter logic [15:0] RECT_BASE = 16'h0000,
    parameter int          H_RES     = 640,
    parameter int          V_RES     = 480,
    parameter int          BATCHES   = 4
)
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    output logic [15:0]                 mem_addr,
    input  logic [15:0]                 mem_rdata,
    output logic [2:0]                  state,
    output logic [COORD_WIDTH-1:0]      coord_generator,
    output logic [RECT_COUNT_WIDTH-1:0] rect_counter,
    output logic [1:0]                  batch_counter,
    output logic                        batch_completed,
    output logic [15:0]                 dout,
    output logic                        busy,
    output logic                        done
);

    localparam logic [COORD_WIDTH-1:0] H_LAST = COORD_WIDTH'(H_RES - 1);
    localparam logic [COORD_WIDTH-1:0] V_LAST = COORD_WIDTH'(V_RES - 1);
    localparam logic [1:0]             B_LAST = 2'(BATCHES - 1);
    localparam logic [RECT_COUNT_WIDTH-1:0] R_LAST =
        RECT_COUNT_WIDTH'(RECTS_PER_BATCH - 1);

    phase_t                      r_state;
    logic                        r_sweep;
    logic [RECT_COUNT_WIDTH-1:0] r_rect;
    logic [COORD_WIDTH-1:0]      r_coord;
    logic [1:0]                  r_batch;
    logic                        r_busy;
    logic                        r_last1;
    logic                        r_last2;
    logic                        r_done;

    phase_t                      w_state_n;
    logic                        w_sweep_n;
    logic [RECT_COUNT_WIDTH-1:0] w_rect_n;
    logic [COORD_WIDTH-1:0]      w_coord_n;
    logic [1:0]                  w_batch_n;
    logic                        w_last;
    logic                        w_accept;
    logic [COORD_WIDTH-1:0]      w_coord_last;
    logic                        w_load;
    logic [5:0]                  w_idx;

    assign w_accept = (r_state == PH_IDLE) && start && !r_busy;

    assign w_coord_last = (r_state == PH_X || r_state == PH_WIDTH)
                          ? H_LAST : V_LAST;

    // r_sweep doubles as batch_completed, so it stays high through COLOR.
    always_comb begin
        w_state_n = r_state;
        w_sweep_n = r_sweep;
        w_rect_n  = r_rect;
        w_coord_n = r_coord;
        w_batch_n = r_batch;
        w_last    = 1'b0;
        case (r_state)
            PH_IDLE: begin
                if (w_accept) begin
                    w_state_n = PH_X;
                    w_sweep_n = 1'b0;
                    w_rect_n  = '0;
                    w_coord_n = '0;
                    w_batch_n = '0;
                end
            end
            PH_X, PH_WIDTH, PH_Y, PH_HEIGHT: begin
                if (!r_sweep) begin
                    if (r_rect == R_LAST) begin
                        w_sweep_n = 1'b1;
                        w_rect_n  = '0;
                        w_coord_n = '0;
                    end else begin
                        w_rect_n = r_rect + 1'b1;
                    end
                end else if (r_coord == w_coord_last) begin
                    w_state_n = next_phase(r_state);
                    w_sweep_n = (r_state == PH_HEIGHT);
                    w_rect_n  = '0;
                    w_coord_n = '0;
                end else begin
                    w_coord_n = r_coord + 1'b1;
                end
            end
            PH_COLOR: begin
                if (r_rect == R_LAST) begin
                    w_rect_n  = '0;
                    w_sweep_n = 1'b0;
                    if (r_batch == B_LAST) begin
                        w_state_n = PH_IDLE;
                        w_batch_n = '0;
                        w_last    = 1'b1;
                    end else begin
                        w_state_n = PH_X;
                        w_batch_n = r_batch + 1'b1;
                    end
                end else begin
                    w_rect_n = r_rect + 1'b1;
                end
            end
            default: begin
                w_state_n = PH_IDLE;
                w_sweep_n = 1'b0;
                w_rect_n  = '0;
                w_coord_n = '0;
                w_batch_n = '0;
            end
        endcase
    end

    // done trails the last COLOR cycle by the 3-cycle data pipeline;
    // busy drops as done rises.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= PH_IDLE;
            r_sweep <= 1'b0;
            r_rect  <= '0;
            r_coord <= '0;
            r_batch <= '0;
            r_busy  <= 1'b0;
            r_last1 <= 1'b0;
            r_last2 <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_sweep <= w_sweep_n;
            r_rect  <= w_rect_n;
            r_coord <= w_coord_n;
            r_batch <= w_batch_n;
            r_last1 <= w_last;
            r_last2 <= r_last1;
            r_done  <= r_last2;
            if (w_accept)
                r_busy <= 1'b1;
            else if (r_last2)
                r_busy <= 1'b0;
        end
    end

    // Record address: RECT_BASE + 5*(16*batch + rect) + field offset.
    assign w_idx    = {r_batch, r_rect};
    assign mem_addr = RECT_BASE + 16'({w_idx, 2'b00}) + 16'(w_idx)
                    + 16'(field_offset(r_state));

    assign w_load = !r_sweep && r_state != PH_IDLE && r_state != PH_COLOR;

    assign state           = r_state;
    assign rect_counter    = r_rect;
    assign batch_counter   = r_batch;
    assign batch_completed = r_sweep;
    assign coord_generator = (r_state == PH_COLOR)
                             ? {4'b0, r_batch, r_rect} : r_coord;
    assign busy            = r_busy;
    assign done            = r_done;

    gpu_rect_fetch_pipe u_pipe (
        .clk     (clk),
        .reset   (reset),
        .i_phase (r_state),
        .i_load  (w_load),
        .i_rect  (r_rect),
        .i_rdata (mem_rdata),
        .o_dout  (dout)
    );

endmodule

// File: tb/tb_gpu_rect_sequencer.sv
// Self-checking bench for gpu_rect_sequencer with a rect memory model.
// Table of per-cycle expectations plus reset / restart sequences.
module tb_gpu_rect_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic [2:0]  state;
    logic [9:0]  coord_generator;
    logic [3:0]  rect_counter;
    logic [1:0]  batch_counter;
    logic        batch_completed;
    logic [15:0] dout;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [512];

    typedef struct {
        int cyc;
        int st;
        int rc;
        int cg;
        int bt;
        int bc;
        int addr;
        int dout;
        int busy;
        int done;
    } vec_t;

    vec_t tab[$];

    gpu_rect_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .mem_addr        (mem_addr),
        .mem_rdata       (mem_rdata),
        .state           (state),
        .coord_generator (coord_generator),
        .rect_counter    (rect_counter),
        .batch_counter   (batch_counter),
        .batch_completed (batch_completed),
        .dout            (dout),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_rdata <= mem[mem_addr[8:0]];

    function automatic vec_t mk(int c, int st, int rc, int cg, int bt,
                                int bc, int a, int d, int bu, int dn);
        vec_t v;
        v.cyc = c; v.st = st; v.rc = rc; v.cg = cg; v.bt = bt;
        v.bc = bc; v.addr = a; v.dout = d; v.busy = bu; v.done = dn;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
        end
    endtask

    task automatic check_vec(vec_t v);
        string p;
        p = $sformatf("c%0d", v.cyc);
        chk({p, ".state"}, 32'(state), v.st);
        chk({p, ".rect"}, 32'(rect_counter), v.rc);
        chk({p, ".coord"}, 32'(coord_generator), v.cg);
        chk({p, ".batch"}, 32'(batch_counter), v.bt);
        chk({p, ".bc"}, 32'(batch_completed), v.bc);
        chk({p, ".busy"}, 32'(busy), v.busy);
        chk({p, ".done"}, 32'(done), v.done);
        if (v.addr >= 0) chk({p, ".addr"}, 32'(mem_addr), v.addr);
        if (v.dout >= 0) chk({p, ".dout"}, 32'(dout), v.dout);
    endtask

    task automatic check_idle(string p);
        chk({p, ".state"}, 32'(state), 0);
        chk({p, ".rect"}, 32'(rect_counter), 0);
        chk({p, ".coord"}, 32'(coord_generator), 0);
        chk({p, ".batch"}, 32'(batch_counter), 0);
        chk({p, ".bc"}, 32'(batch_completed), 0);
        chk({p, ".addr"}, 32'(mem_addr), 0);
        chk({p, ".dout"}, 32'(dout), 0);
        chk({p, ".busy"}, 32'(busy), 0);
        chk({p, ".done"}, 32'(done), 0);
    endtask

    // Leaves the bench at the falling edge of active cycle 1.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 512; a++) mem[a] = 16'(a);
        mem[0]   = 16'd100;
        mem[2]   = 16'd50;
        mem[5]   = 16'd1000;
        mem[6]   = 16'd470;
        mem[7]   = 16'd100;
        mem[8]   = 16'd5;
        mem[199] = 16'hABCD;

        //           cyc   st rc  cg  bt bc addr  dout  bu dn
        tab.push_back(mk(1,    1, 0,  0,  0, 0, 0,    -1,   1, 0));
        tab.push_back(mk(2,    1, 1,  0,  0, 0, 5,    -1,   1, 0));
        tab.push_back(mk(4,    1, 3,  0,  0, 0, 15,   100,  1, 0));
        tab.push_back(mk(5,    1, 4,  0,  0, 0, 20,   1000, 1, 0));
        tab.push_back(mk(16,   1, 15, 0,  0, 0, 75,   60,   1, 0));
        tab.push_back(mk(17,   1, 0,  0,  0, 1, -1,   65,   1, 0));
        tab.push_back(mk(19,   1, 0,  2,  0, 1, -1,   75,   1, 0));
        tab.push_back(mk(20,   1, 0,  3,  0, 1, -1,   0,    1, 0));
        tab.push_back(mk(656,  1, 0,  639, 0, 1, -1,  0,    1, 0));
        tab.push_back(mk(657,  2, 0,  0,  0, 0, 2,    0,    1, 0));
        tab.push_back(mk(660,  2, 3,  0,  0, 0, 17,   150,  1, 0));
        tab.push_back(mk(661,  2, 4,  0,  0, 0, 22,   1023, 1, 0));
        tab.push_back(mk(1001, 2, 0,  328, 0, 1, -1,  0,    1, 0));
        tab.push_back(mk(1002, 2, 0,  329, 0, 1, -1,  0,    1, 0));
        tab.push_back(mk(1317, 3, 4,  0,  0, 0, 21,   470,  1, 0));
        tab.push_back(mk(1808, 3, 0,  479, 0, 1, -1,  0,    1, 0));
        tab.push_back(mk(1809, 4, 0,  0,  0, 0, 3,    0,    1, 0));
        tab.push_back(mk(1813, 4, 4,  0,  0, 0, 23,   475,  1, 0));
        tab.push_back(mk(2304, 4, 0,  479, 0, 1, -1,  0,    1, 0));
        tab.push_back(mk(2305, 5, 0,  0,  0, 1, 4,    0,    1, 0));
        tab.push_back(mk(2308, 5, 3,  3,  0, 1, 19,   4,    1, 0));
        tab.push_back(mk(2320, 5, 15, 15, 0, 1, 79,   -1,   1, 0));
        tab.push_back(mk(2321, 1, 0,  0,  1, 0, 80,   -1,   1, 0));
        tab.push_back(mk(6952, 5, 7,  39, 2, 1, 199,  -1,   1, 0));
        tab.push_back(mk(6955, 5, 10, 42, 2, 1, 214,  43981, 1, 0));
        tab.push_back(mk(9280, 5, 15, 63, 3, 1, 319,  -1,   1, 0));
        tab.push_back(mk(9281, 0, 0,  0,  0, 0, 0,    309,  1, 0));
        tab.push_back(mk(9282, 0, 0,  0,  0, 0, 0,    -1,   1, 0));
        tab.push_back(mk(9283, 0, 0,  0,  0, 0, 0,    319,  0, 1));
        tab.push_back(mk(9284, 0, 0,  0,  0, 0, 0,    0,    0, 0));

        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_idle("rst0");

        // Frame 1: table checks, stray start mid-frame.
        begin
            int done_at;
            done_at = 0;
            pulse_start();
            for (int n = 1; n <= 9290; n++) begin
                if (n > 1) @(negedge clk);
                if (done === 1'b1 && done_at == 0) done_at = n;
                foreach (tab[i])
                    if (tab[i].cyc == n) check_vec(tab[i]);
                if (n == 1000) start = 1'b1;
                if (n == 1001) start = 1'b0;
            end
            chk("f1.done_cycle", 32'(done_at), 9283);
        end

        // Frame 2: reset at cycle 3000, start held during reset.
        begin
            int stray;
            stray = 0;
            pulse_start();
            for (int n = 1; n < 3000; n++) @(negedge clk);
            chk("f2.busy_before_rst", 32'(busy), 1);
            reset = 1'b1;
            @(negedge clk);
            check_idle("f2.rst");
            start = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            start = 1'b0;
            chk("f2.start_in_rst.busy", 32'(busy), 0);
            chk("f2.start_in_rst.state", 32'(state), 0);
            for (int n = 0; n < 8; n++) begin
                @(negedge clk);
                if (done !== 1'b0 || busy !== 1'b0 || state !== 3'd0)
                    stray++;
            end
            chk("f2.quiet_after_rst", 32'(stray), 0);
        end

        // Frame 3: full frame after the aborted one.
        begin
            int done_at;
            done_at = 0;
            pulse_start();
            chk("f3.busy_c1", 32'(busy), 1);
            chk("f3.state_c1", 32'(state), 1);
            for (int n = 1; n <= 9400 && done_at == 0; n++) begin
                if (n > 1) @(negedge clk);
                if (done === 1'b1) done_at = n;
            end
            chk("f3.done_cycle", 32'(done_at), 9283);
            @(negedge clk);
            check_idle("f3.end");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
